// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply unit and the control
// decoder. Holds the EX-stage ALUCtr codes for the HI/LO instruction group,
// the multiply FSM state enumeration, the iteration count and small helpers.
package hilo_pkg;

    localparam logic [4:0] ALU_MULT = 5'b10110;
    localparam logic [4:0] ALU_MTLO = 5'b10111;
    localparam logic [4:0] ALU_MTHI = 5'b11000;
    localparam logic [4:0] ALU_MFLO = 5'b11001;
    localparam logic [4:0] ALU_MFHI = 5'b11010;

    // One shift-add step per multiplier bit.
    localparam logic [5:0] MUL_STEPS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } hilo_state_e;

    // True for any of the five codes handled by the HI/LO unit.
    function automatic logic is_hilo_op(input logic [4:0] ctr);
        logic hit;
        case (ctr)
            ALU_MULT, ALU_MTLO, ALU_MTHI, ALU_MFLO, ALU_MFHI: hit = 1'b1;
            default:                                         hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Unsigned magnitude of a two's-complement word. 0x80000000 maps to
    // itself, which read as unsigned is exactly 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        logic [31:0] m;
        if (v[31]) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// mul_iter_core: iterative signed 32x32 -> 64 multiplier datapath.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   start      : latch |op_a|, |op_b| and the result sign, clear product/counter
//   step       : perform one radix-2 shift-add step
//   op_a, op_b : signed operands (rs, rt)
//   result     : signed 64-bit product (negated magnitude when sign is set)
//   last_step  : the step taken this cycle is the final one
module mul_iter_core
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] result,
    output logic        last_step
);

    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;

    // Next-state for the shift-add datapath.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        if (start) begin
            mcand_d  = {32'd0, abs32(op_a)};
            mplier_d = abs32(op_b);
            prod_d   = 64'd0;
            cnt_d    = 6'd0;
            sign_d   = op_a[31] ^ op_b[31];
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end else begin
                prod_d = prod_q;
            end
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + 6'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            cnt_q    <= 6'd0;
            sign_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    // Counter reaches MUL_STEPS on the edge that takes this step.
    always_comb begin
        last_step = (cnt_q == (MUL_STEPS - 6'd1));
        if (sign_q) begin
            result = ~prod_q + 64'd1;
        end else begin
            result = prod_q;
        end
    end

endmodule

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: HI/LO register file with an iterative MULT, MTHI/MTLO
// writes, MFHI/MFLO reads and pipeline stall generation.
// Ports:
//   clk, rst         : clock and asynchronous active-high reset
//   alu_ctr          : EX-stage ALUCtr (MULT/MTLO/MTHI/MFLO/MFHI, others no-op)
//   ex_valid         : EX-stage slot holds a real instruction
//   rs_val, rt_val   : forwarded operands
//   hilo_rd          : HI (MFHI) or LO (MFLO) on an accepted read, else 0
//   busy             : multiply in progress (CALC or DONE)
//   stall            : freeze IF/ID/EX and bubble MEM
//   hi, lo           : architectural HI/LO registers
module hilo_mul_unit
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_ctr,
    input  logic        ex_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hilo_rd,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    hilo_state_e state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        presented_s;
    logic        accept_s;
    logic        start_s;
    logic        step_s;
    logic [63:0] result_s;
    logic        last_step_s;

    mul_iter_core u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .step      (step_s),
        .op_a      (rs_val),
        .op_b      (rt_val),
        .result    (result_s),
        .last_step (last_step_s)
    );

    // Handshake: any HI/LO op waits while a multiply is outstanding,
    // including the DONE cycle, so readers see the final HI/LO.
    always_comb begin
        presented_s = ex_valid && is_hilo_op(alu_ctr);
        busy        = (state_q != ST_IDLE);
        stall       = busy && presented_s;
        accept_s    = presented_s && (state_q == ST_IDLE);
    end

    // FSM next-state, HI/LO write-back and core control.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start_s = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (alu_ctr)
                        ALU_MULT: begin
                            start_s = 1'b1;
                            state_d = ST_CALC;
                        end
                        ALU_MTLO: lo_d = rs_val;
                        ALU_MTHI: hi_d = rs_val;
                        default:  state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                if (last_step_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                hi_d    = result_s[63:32];
                lo_d    = result_s[31:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Read port shows the registered value; a same-cycle write is not bypassed.
    always_comb begin
        if (accept_s && (alu_ctr == ALU_MFHI)) begin
            hilo_rd = hi_q;
        end else if (accept_s && (alu_ctr == ALU_MFLO)) begin
            hilo_rd = lo_q;
        end else begin
            hilo_rd = 32'd0;
        end
        hi = hi_q;
        lo = lo_q;
    end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Scoreboard bench for hilo_mul_unit: stimulus pushes expected read data or
// expected HI/LO results; a negedge monitor pops and compares them when the
// DUT accepts a read or finishes a multiply.
module tb_hilo_mul_unit;
    import hilo_pkg::*;

    localparam logic [4:0] ALU_ADDU = 5'b00010;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_ctr;
    logic        ex_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hilo_rd;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_mul_unit dut (
        .clk      (clk),
        .rst      (rst),
        .alu_ctr  (alu_ctr),
        .ex_valid (ex_valid),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hilo_rd  (hilo_rd),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        string       name;
        logic        is_mul;   // 1: compare {hi,lo} at busy fall; 0: compare hilo_rd
        logic [63:0] val;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    logic busy_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic is_mul, input logic [63:0] v);
        exp_t e;
        e.name = nm;
        e.is_mul = is_mul;
        e.val = v;
        expq.push_back(e);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (busy_prev && !busy && !rst) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mul_done: hi=%h lo=%h", hi, lo);
            end else begin
                e = expq.pop_front();
                check(e.name, {hi, lo}, e.is_mul ? e.val : 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        if (ex_valid && !stall && !rst && ((alu_ctr == ALU_MFHI) || (alu_ctr == ALU_MFLO))) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: hilo_rd=%h", hilo_rd);
            end else begin
                e = expq.pop_front();
                check(e.name, {32'd0, hilo_rd}, e.is_mul ? 64'hFFFF_FFFF_FFFF_FFFF : e.val);
            end
        end
        busy_prev = busy;
    end

    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_ctr  = c;
        rs_val   = a;
        rt_val   = b;
        ex_valid = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        alu_ctr  = ALU_ADDU;
    endtask

    task automatic mult_run(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        int cnt;
        cnt = 0;
        push(nm, 1'b1, exp);
        issue(ALU_MULT, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        check({nm, "_busy_cycles"}, 64'(cnt), 64'd33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst      = 1'b1;
        ex_valid = 1'b0;
        alu_ctr  = 5'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Accepted on the first edge after reset release.
        mult_run("mult_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        mult_run("mult_m1x1", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        mult_run("mult_min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mult_run("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);

        // MFHI presented two cycles after MULT 7x9 stalls until after E33.
        push("mult_7x9", 1'b1, 64'h0000_0000_0000_003F);
        push("mfhi_after_mult", 1'b0, 64'h0000_0000_0000_0000);
        issue(ALU_MULT, 32'd7, 32'd9);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        alu_ctr  = ALU_MFHI;
        ex_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
        end
        check("mfhi_stall_cycles", 64'(cnt), 64'd31);
        check("mfhi_busy_released", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        push("mflo_after_mult", 1'b0, 64'h0000_0000_0000_003F);
        issue(ALU_MFLO, 32'd0, 32'd0);

        // Idle MTHI then MFHI; LO untouched.
        issue(ALU_MTHI, 32'h1234_5678, 32'd0);
        push("mfhi_after_mthi", 1'b0, 64'h0000_0000_1234_5678);
        issue(ALU_MFHI, 32'd0, 32'd0);
        @(negedge clk);
        check("mthi_lo_unchanged", {32'd0, lo}, 64'h0000_0000_0000_003F);
        check("mthi_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);

        // Reset in the middle of CALC abandons the multiply.
        @(posedge clk);
        #1;
        issue(ALU_MULT, 32'd2, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("post_rst_hi", {32'd0, hi}, 64'd0);
        check("post_rst_lo", {32'd0, lo}, 64'd0);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        // Non-HI/LO op and invalid slot while busy do not stall.
        @(posedge clk);
        #1;
        issue(ALU_MTLO, 32'hA5A5_A5A5, 32'd0);
        push("mult_6x7", 1'b1, 64'h0000_0000_0000_002A);
        issue(ALU_MULT, 32'd6, 32'd7);
        alu_ctr  = ALU_ADDU;
        ex_valid = 1'b1;
        @(negedge clk);
        check("addu_busy", {63'd0, busy}, 64'd1);
        check("addu_stall", {63'd0, stall}, 64'd0);
        check("addu_rd", {32'd0, hilo_rd}, 64'd0);
        @(posedge clk);
        #1;
        alu_ctr  = ALU_MTLO;
        ex_valid = 1'b0;
        rs_val   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("inv_mtlo_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        alu_ctr = ALU_ADDU;
        @(negedge clk);
        check("inv_mtlo_lo", {32'd0, lo}, 64'h0000_0000_A5A5_A5A5);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        check("mult_6x7_finished", {63'd0, busy}, 64'd0);

        @(posedge clk);
        #1;
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
